// File: rtl/rv32i_types.sv
// Shared RV32 types: M-extension operation codes and the mul/div sequencer states,
// plus small decode helpers used by the execute-stage multiply/divide unit.
package rv32i_types;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } muldiv_state_t;

  // Counter preload: one CALC cycle per operand bit, ending when the counter reads 0.
  localparam logic [5:0] MD_CALC_LAST = 6'd31;

  function automatic logic md_is_div(input muldiv_funct3_t op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic md_is_rem(input muldiv_funct3_t op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  function automatic logic md_a_signed(input muldiv_funct3_t op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_b_signed(input muldiv_funct3_t op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring divide on
// magnitudes, a sign-fix cycle, then a one-cycle done pulse with a held result.
module ex_muldiv
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_t   r_state;
  muldiv_funct3_t  r_op;
  logic            r_neg;
  logic [5:0]      r_cnt;
  logic [XLEN-1:0] r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  muldiv_funct3_t  w_op;
  logic            w_sa, w_sb, w_neg;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic            w_div_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_special_val;
  logic [XLEN:0]   w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_prod;
  logic [XLEN-1:0] w_div_diff, w_div_mag, w_div_res, w_fix_val;
  logic            w_div_ge;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Operand decode for the request sitting in ID/EX.
  always_comb begin
    w_op       = muldiv_funct3_t'(funct3);
    w_sa       = md_a_signed(w_op) & rs1_data[XLEN-1];
    w_sb       = md_b_signed(w_op) & rs2_data[XLEN-1];
    w_mag_a    = w_sa ? -rs1_data : rs1_data;
    w_mag_b    = w_sb ? -rs2_data : rs2_data;
    w_neg      = md_is_rem(w_op) ? w_sa : (w_sa ^ w_sb);
    w_div_zero = md_is_div(w_op) && (rs2_data == '0);
    w_ovf      = (w_op inside {MD_DIV, MD_REM}) && (rs1_data == MIN_NEG) && (rs2_data == '1);
    w_special  = w_div_zero | w_ovf;
    w_special_val = '0;
    if (w_div_zero)
      w_special_val = md_is_rem(w_op) ? rs1_data : '1;
    else if (w_ovf)
      w_special_val = md_is_rem(w_op) ? '0 : MIN_NEG;
  end

  // One iteration of each algorithm; the accumulator holds {hi, lo} for both.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    // The shifted partial remainder is XLEN+1 bits wide, but when it is >= the
    // divisor the difference always fits in XLEN bits.
    w_div_ge   = r_acc[2*XLEN-1:XLEN-1] >= {1'b0, r_opnd};
    w_div_diff = r_acc[2*XLEN-2:XLEN-1] - r_opnd;
    w_div_next = {w_div_ge ? w_div_diff : r_acc[2*XLEN-2:XLEN-1],
                  r_acc[XLEN-2:0], w_div_ge};
  end

  always_comb begin
    w_prod    = r_neg ? -r_acc : r_acc;
    w_div_mag = md_is_rem(r_op) ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    w_div_res = r_neg ? -w_div_mag : w_div_mag;
    unique case (r_op)
      MD_MUL:                       w_fix_val = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fix_val = w_prod[2*XLEN-1:XLEN];
      default:                      w_fix_val = w_div_res;
    endcase
  end

  always_comb begin
    stall = ((r_state == MD_IDLE) && start && !flush) ||
            (r_state == MD_CALC) || (r_state == MD_FIX);
  end

  // NOTE: every register here is a flop, so all updates use <=; blocking
  // assignments would make the CALC step see partially updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= MD_IDLE;
      r_op     <= MD_MUL;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        MD_IDLE: begin
          if (start && !flush) begin
            r_op  <= w_op;
            r_neg <= w_neg;
            r_cnt <= MD_CALC_LAST;
            if (w_special) begin
              r_result <= w_special_val;
              r_done   <= 1'b1;
              r_state  <= MD_DONE;
            end else begin
              r_opnd  <= md_is_div(w_op) ? w_mag_b : w_mag_a;
              r_acc   <= {{XLEN{1'b0}}, md_is_div(w_op) ? w_mag_a : w_mag_b};
              r_state <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          if (flush) begin
            r_state <= MD_IDLE;
          end else begin
            r_acc <= md_is_div(r_op) ? w_div_next : w_mul_next;
            if (r_cnt == '0) r_state <= MD_FIX;
            else             r_cnt   <= r_cnt - 6'd1;
          end
        end
        MD_FIX: begin
          if (flush) begin
            r_state <= MD_IDLE;
          end else begin
            r_result <= w_fix_val;
            r_done   <= 1'b1;
            r_state  <= MD_DONE;
          end
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: an arithmetic reference model drives a
// per-cycle compare of stall/done/result, plus directed vectors with literal answers.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        stall, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_val(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    bit ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = op[2] && ((b == 0) ||
              ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return special ? 1 : 34;
  endfunction

  // Model: one busy window per accepted request, ending in a done cycle.
  bit          m_busy = 1'b0;
  int          m_done_cyc = 0;
  logic [31:0] m_pending = '0;
  logic [31:0] m_result = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   = 1'b0;
      m_result = '0;
    end else if (m_busy) begin
      if (cyc == m_done_cyc)           m_busy = 1'b0;
      else if (flush)                  m_busy = 1'b0;
      else if (cyc + 1 == m_done_cyc)  m_result = m_pending;
    end else if (start && !flush) begin
      m_busy     = 1'b1;
      m_done_cyc = cyc + ref_lat(funct3, rs1_data, rs2_data);
      m_pending  = ref_val(funct3, rs1_data, rs2_data);
      if (m_done_cyc == cyc + 1) m_result = m_pending;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall",  {31'd0, stall}, {31'd0, m_busy ? (cyc < m_done_cyc) : (start && !flush)});
      check("done",   {31'd0, done},  {31'd0, m_busy && (cyc == m_done_cyc)});
      check("result", result, m_result);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int d, output bit seen);
    seen = 1'b0;
    d = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        d = cyc;
      end
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int s, d;
    bit seen;
    check({name, "_model"}, ref_val(op, a, b), exp);
    next_cycle();
    start = 1'b1; funct3 = op; rs1_data = a; rs2_data = b;
    s = cyc;
    next_cycle();
    start = 1'b0;
    wait_done(d, seen);
    if (!seen) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_latency"}, 32'(d - s), 32'(lat));
      check({name, "_value"}, result, exp);
    end
  endtask

  initial begin
    int s, d;
    bit seen;
    logic [31:0] held;

    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    do_op("mul",       3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    do_op("mulh",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
    do_op("mulhu",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    do_op("mulhsu",    3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34);
    do_op("mulhsu_mn", 3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34);
    do_op("div",       3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    do_op("rem",       3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
    do_op("divu",      3'd5, 32'd100,        32'd7,         32'd14,        34);
    do_op("remu",      3'd7, 32'd100,        32'd7,         32'd2,         34);
    do_op("div_mn3",   3'd4, 32'h8000_0000,  32'd3,         32'hD555_5556, 34);
    do_op("rem_mn3",   3'd6, 32'h8000_0000,  32'd3,         32'hFFFF_FFFE, 34);
    do_op("divu_z",    3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    do_op("rem_z",     3'd6, 32'd5,          32'd0,         32'd5,         1);
    do_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    do_op("mul_b2b",   3'd0, 32'd6,          32'd9,         32'd54,        34);

    // Flush abort: MUL killed in cycle 10, new DIVU started in cycle 12.
    held = result;
    next_cycle();
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd5;
    s = cyc;
    next_cycle();
    start = 1'b0;
    repeat (9) next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    check("flush_stall_c11", {31'd0, stall}, 32'd0);
    check("flush_result_held", result, held);
    next_cycle();
    start = 1'b1; funct3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7;
    next_cycle();
    start = 1'b0;
    wait_done(d, seen);
    if (!seen) check("flush_timeout", 32'd0, 32'd1);
    else begin
      check("flush_new_latency", 32'(d - s), 32'd46);
      check("flush_new_value", result, 32'd14);
    end

    // Asynchronous reset in the middle of CALC cycle 20.
    next_cycle();
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD;
    next_cycle();
    start = 1'b0;
    repeat (19) next_cycle();
    check("pre_reset_stall", {31'd0, stall}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_stall", {31'd0, stall}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_result", result, 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    do_op("mul_after_rst", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    do_op("remu_after_rst", 3'd7, 32'hFFFF_FFFF, 32'd16, 32'd15, 34);

    next_cycle();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
